// File: rtl/score_pkg.sv
// Shared types and constants for the score keeper: hit types, game-FSM state codes
// and the internal score FSM encoding.
package score_pkg;

  typedef enum logic [1:0] {
    HIT_NONE  = 2'd0,
    HIT_PINK  = 2'd1,
    HIT_GREEN = 2'd2,
    HIT_TURQ  = 2'd3
  } hit_type_t;

  localparam logic [2:0] GS_TITLE   = 3'd0;
  localparam logic [2:0] GS_PLAY    = 3'd1;
  localparam logic [2:0] GS_WIN     = 3'd4;
  localparam logic [2:0] GS_RESTART = 3'd6;

  typedef enum logic [1:0] {
    SK_IDLE  = 2'd0,
    SK_PLAY  = 2'd1,
    SK_BONUS = 2'd2,
    SK_DONE  = 2'd3
  } sk_state_t;

  // Title and restart both wipe the running score.
  function automatic logic is_clear(input logic [2:0] gs);
    return (gs == GS_TITLE) || (gs == GS_RESTART);
  endfunction

endpackage

// File: rtl/bcd2_add.sv
// Two-digit BCD adder for a 0..3 increment on the tens digit; saturates at 99.
module bcd2_add (
  input  logic [3:0] hund,
  input  logic [3:0] tens,
  input  logic [1:0] inc,
  output logic [3:0] sum_hund,
  output logic [3:0] sum_tens
);

  logic [4:0] raw;

  always_comb begin
    raw      = {1'b0, tens} + {3'b000, inc};
    sum_hund = hund;
    sum_tens = raw[3:0];
    if (raw > 5'd9) begin
      if (hund == 4'd9) begin
        sum_hund = 4'd9;
        sum_tens = 4'd9;
      end else begin
        sum_hund = hund + 4'd1;
        sum_tens = 4'(raw - 5'd10);
      end
    end
  end

endmodule

// File: rtl/score_keeper.sv
// Game score keeper with BCD score, high score and end-of-game accuracy bonus.
// Define SCORE_ACCURACY_BONUS_EN to enable the fire_count based bonus count-up.
module score_keeper
  import score_pkg::*;
#(
  parameter int SHOT_BASE = 21,
  parameter int BONUS_MAX = 10
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [2:0] curr_state,
  input  logic       hit_valid,
  input  logic [1:0] hit_type,
  input  logic [9:0] fire_count,
  output logic [3:0] hundreds,
  output logic [3:0] ten_out,
  output logic [3:0] hi_hundreds,
  output logic [3:0] hi_tens,
  output logic       bonus_busy
);

  localparam int CNT_W = $clog2(BONUS_MAX + 1);

  sk_state_t        state_reg, state_next;
  logic [3:0]       hund_reg, tens_reg;
  logic [3:0]       hi_hund_reg, hi_tens_reg;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [CNT_W-1:0] bonus_load;
  logic [1:0]       add_inc;
  logic [3:0]       sum_hund, sum_tens;
  logic             clear;
  logic             enter_done;

`ifdef SCORE_ACCURACY_BONUS_EN
  localparam logic [9:0] SHOT_BASE_V = 10'(SHOT_BASE);
  localparam logic [9:0] BONUS_MAX_V = 10'(BONUS_MAX);
  logic [9:0] over_shots;

  // Fewer shots than the base earns the full bonus; each extra shot costs one.
  always_comb begin
    over_shots = fire_count - SHOT_BASE_V;
    if (fire_count < SHOT_BASE_V)
      bonus_load = CNT_W'(BONUS_MAX);
    else if (over_shots >= BONUS_MAX_V)
      bonus_load = '0;
    else
      bonus_load = CNT_W'(BONUS_MAX_V - over_shots);
  end
`else
  logic unused_cfg;
  assign unused_cfg = ^{fire_count, SHOT_BASE[0]};
  assign bonus_load = '0;
`endif

  // Single adder shared by hits (PLAY) and bonus ticks (BONUS).
  bcd2_add u_add (
    .hund     (hund_reg),
    .tens     (tens_reg),
    .inc      (add_inc),
    .sum_hund (sum_hund),
    .sum_tens (sum_tens)
  );

  always_comb begin
    clear      = is_clear(curr_state);
    state_next = state_reg;
    cnt_next   = cnt_reg;
    add_inc    = 2'd0;
    enter_done = 1'b0;
    if (clear) begin
      state_next = SK_IDLE;
      cnt_next   = '0;
    end else begin
      case (state_reg)
        SK_IDLE: begin
          if (curr_state == GS_PLAY) state_next = SK_PLAY;
        end
        SK_PLAY: begin
          // A hit on the exit cycle still counts.
          if (hit_valid && (hit_type != HIT_NONE)) add_inc = hit_type;
          if (curr_state == GS_WIN) begin
            state_next = SK_BONUS;
            cnt_next   = bonus_load;
          end
        end
        SK_BONUS: begin
          if (cnt_reg != '0) begin
            add_inc  = 2'd1;
            cnt_next = cnt_reg - CNT_W'(1);
          end else begin
            state_next = SK_DONE;
            enter_done = 1'b1;
          end
        end
        SK_DONE: ;
        default: state_next = SK_IDLE;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_reg   <= SK_IDLE;
      hund_reg    <= 4'd0;
      tens_reg    <= 4'd0;
      hi_hund_reg <= 4'd0;
      hi_tens_reg <= 4'd0;
      cnt_reg     <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      if (clear) begin
        hund_reg <= 4'd0;
        tens_reg <= 4'd0;
      end else begin
        hund_reg <= sum_hund;
        tens_reg <= sum_tens;
      end
      // BCD digits compare correctly as a plain 8-bit number.
      if (enter_done && ({hund_reg, tens_reg} > {hi_hund_reg, hi_tens_reg})) begin
        hi_hund_reg <= hund_reg;
        hi_tens_reg <= tens_reg;
      end
    end
  end

  assign hundreds    = hund_reg;
  assign ten_out     = tens_reg;
  assign hi_hundreds = hi_hund_reg;
  assign hi_tens     = hi_tens_reg;
  assign bonus_busy  = (cnt_reg != '0);

endmodule

// File: tb/tb_score_keeper.sv
// Directed self-checking bench for score_keeper; bonus expectations follow
// whether SCORE_ACCURACY_BONUS_EN is defined.
module tb_score_keeper;

  logic       Clk;
  logic       Reset;
  logic [2:0] curr_state;
  logic       hit_valid;
  logic [1:0] hit_type;
  logic [9:0] fire_count;
  logic [3:0] hundreds, ten_out, hi_hundreds, hi_tens;
  logic       bonus_busy;

  int total = 0;
  int bad   = 0;
  int n_busy;

`ifdef SCORE_ACCURACY_BONUS_EN
  localparam int B1_CYC = 7;
  localparam int B1_H   = 4;
  localparam int B1_T   = 9;
  localparam int B3_CYC = 10;
  localparam int B3_H   = 1;
  localparam int B3_T   = 0;
`else
  localparam int B1_CYC = 0;
  localparam int B1_H   = 4;
  localparam int B1_T   = 2;
  localparam int B3_CYC = 0;
  localparam int B3_H   = 0;
  localparam int B3_T   = 0;
`endif

  score_keeper #(.SHOT_BASE(21), .BONUS_MAX(10)) dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .curr_state  (curr_state),
    .hit_valid   (hit_valid),
    .hit_type    (hit_type),
    .fire_count  (fire_count),
    .hundreds    (hundreds),
    .ten_out     (ten_out),
    .hi_hundreds (hi_hundreds),
    .hi_tens     (hi_tens),
    .bonus_busy  (bonus_busy)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end else begin
      $display("[%0t] ok %s = %0d", $time, tag, got);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic hit(input logic [1:0] k);
    hit_valid = 1'b1;
    hit_type  = k;
    tick();
    hit_valid = 1'b0;
    hit_type  = 2'd0;
  endtask

  task automatic count_busy(output int n);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      if (!bonus_busy) break;
      n++;
      tick();
    end
  endtask

  initial begin
    Reset      = 1'b1;
    curr_state = 3'd0;
    hit_valid  = 1'b0;
    hit_type   = 2'd0;
    fire_count = 10'd0;
    tick();
    tick();
    Reset = 1'b0;
    chk("rst_hund", hundreds, 0);
    chk("rst_tens", ten_out, 0);
    chk("rst_hi_h", hi_hundreds, 0);
    chk("rst_hi_t", hi_tens, 0);
    chk("rst_busy", bonus_busy, 0);

    // Hits ignored in IDLE
    hit(2'd3);
    chk("idle_hit", ten_out, 0);

    curr_state = 3'd1;
    tick();
    hit(2'd1);
    chk("lat1_tens", ten_out, 1);
    hit(2'd2);
    hit(2'd3);
    chk("start_hund", hundreds, 0);
    chk("start_tens", ten_out, 6);

    hit(2'd2);
    chk("pre_carry", ten_out, 8);
    hit(2'd3);
    chk("carry_hund", hundreds, 1);
    chk("carry_tens", ten_out, 1);
    hit(2'd0);
    chk("type0_tens", ten_out, 1);

    for (int i = 0; i < 29; i++) hit(2'd3);
    chk("s98_hund", hundreds, 9);
    chk("s98_tens", ten_out, 8);
    hit(2'd3);
    chk("sat_hund", hundreds, 9);
    chk("sat_tens", ten_out, 9);
    hit(2'd1);
    chk("sat2_hund", hundreds, 9);
    chk("sat2_tens", ten_out, 9);

    // Game 1: score 42, fire_count 24
    curr_state = 3'd0;
    tick();
    chk("clr_hund", hundreds, 0);
    chk("clr_tens", ten_out, 0);
    curr_state = 3'd1;
    tick();
    for (int i = 0; i < 14; i++) hit(2'd3);
    chk("g1_hund", hundreds, 4);
    chk("g1_tens", ten_out, 2);
    fire_count = 10'd24;
    curr_state = 3'd4;
    tick();
    count_busy(n_busy);
    tick();
    chk("g1_busy_cyc", n_busy, B1_CYC);
    chk("g1_fin_hund", hundreds, B1_H);
    chk("g1_fin_tens", ten_out, B1_T);
    chk("g1_hi_h", hi_hundreds, B1_H);
    chk("g1_hi_t", hi_tens, B1_T);
    chk("g1_done_busy", bonus_busy, 0);

    // Clear wins over a simultaneous hit
    curr_state = 3'd6;
    hit_valid  = 1'b1;
    hit_type   = 2'd3;
    tick();
    hit_valid = 1'b0;
    hit_type  = 2'd0;
    chk("clrpri_hund", hundreds, 0);
    chk("clrpri_tens", ten_out, 0);
    chk("clrpri_hi_h", hi_hundreds, B1_H);
    chk("clrpri_hi_t", hi_tens, B1_T);

    // Game 2: hit on the PLAY exit cycle, fire_count at the zero-bonus boundary
    curr_state = 3'd1;
    tick();
    hit(2'd3);
    fire_count = 10'd31;
    curr_state = 3'd4;
    hit_valid  = 1'b1;
    hit_type   = 2'd2;
    tick();
    hit_valid = 1'b0;
    hit_type  = 2'd0;
    chk("g2_exit_hit", ten_out, 5);
    chk("g2_busy", bonus_busy, 0);
    tick();
    chk("g2_hi_h", hi_hundreds, B1_H);
    chk("g2_hi_t", hi_tens, B1_T);

    // Game 3: fewer shots than the base -> full bonus
    curr_state = 3'd0;
    tick();
    curr_state = 3'd1;
    tick();
    fire_count = 10'd5;
    curr_state = 3'd4;
    tick();
    count_busy(n_busy);
    tick();
    chk("g3_busy_cyc", n_busy, B3_CYC);
    chk("g3_fin_hund", hundreds, B3_H);
    chk("g3_fin_tens", ten_out, B3_T);
    chk("g3_hi_h", hi_hundreds, B1_H);

    // Reset while in BONUS
    curr_state = 3'd0;
    tick();
    curr_state = 3'd1;
    tick();
    for (int i = 0; i < 10; i++) hit(2'd3);
    chk("g4_tens", ten_out, 0);
    chk("g4_hund", hundreds, 3);
    fire_count = 10'd24;
    curr_state = 3'd4;
    tick();
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    chk("rb_hund", hundreds, 0);
    chk("rb_tens", ten_out, 0);
    chk("rb_hi_h", hi_hundreds, 0);
    chk("rb_hi_t", hi_tens, 0);
    chk("rb_busy", bonus_busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/score_keeper.md
SCORE_KEEPER -- requirements
Module: score_keeper

Interface
REQ-001 SHALL have parameter SHOT_BASE, default 21, meaning minimum shots needed to clear all aliens (accuracy reference).
REQ-002 SHALL have parameter BONUS_MAX, default 10, meaning maximum accuracy bonus in tens-of-points units.
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 Port: Clk  in  1  system clock; all state changes on rising edge.
REQ-005 Port: Reset  in  1  synchronous active-high reset.
REQ-006 Port: curr_state  in  3  game FSM state: 0 = title, 1 = play, 4 = win, 6 = restart.
REQ-007 Port: hit_valid  in  1  single-cycle alien-destroyed pulse.
REQ-008 Port: hit_type  in  2  1 = pink (10 pts), 2 = green (20 pts), 3 = turquoise (30 pts), 0 = no points.
REQ-009 Port: fire_count  in  10  shots fired this game.
REQ-010 Port: hundreds  out  4  BCD hundreds digit of current score.
REQ-011 Port: ten_out  out  4  BCD tens digit of current score; the ones digit is implicitly 0.
REQ-012 Port: hi_hundreds, hi_tens  out  4 each  BCD high-score digits.
REQ-013 Port: bonus_busy  out  1  high while the bonus count-up is in progress.

Function
REQ-014 Score SHALL be held as two BCD digits in tens-of-points units (00..99, i.e. 0..990 points).
REQ-015 FSM states SHALL be IDLE, PLAY, BONUS and DONE.
REQ-016 IDLE -> PLAY when curr_state == 1.
REQ-017 PLAY -> BONUS when curr_state == 4.
REQ-018 BONUS -> DONE when the bonus counter reaches 0.
REQ-019 Any state -> IDLE when curr_state is 0 or 6.
REQ-020 In PLAY, a hit with hit_valid = 1 and hit_type = k SHALL add k tens; the sum SHALL be visible on the outputs the next cycle (latency 1).
REQ-021 Tens carry: when ten_out + k > 9, tens becomes ten_out + k - 10 and hundreds increments.
REQ-022 Saturation: when a carry occurs with hundreds == 9, the score SHALL hold at 99 tens.
REQ-023 Hits SHALL be ignored in IDLE, BONUS and DONE, and whenever hit_type == 0.
REQ-024 On entering BONUS, the bonus counter SHALL load BONUS_MAX - (fire_count - SHOT_BASE).
- If fire_count - SHOT_BASE >= BONUS_MAX, the counter SHALL load 0.
- If fire_count < SHOT_BASE, the counter SHALL load BONUS_MAX.
REQ-025 In BONUS, each cycle SHALL add 1 ten (saturating) and decrement the counter; bonus_busy = 1 while counter != 0.
REQ-026 On entering DONE, if score > high score (BCD compare, hundreds first), the high score SHALL load the score on that same edge.
REQ-027 Entry into IDLE SHALL clear the score and the bonus counter; the high score SHALL be retained.
REQ-028 A hit and a clear condition in the same cycle: clear SHALL win.
REQ-029 The transition out of PLAY and a hit in the same cycle: the hit SHALL still be scored.

Reset
REQ-030 Reset SHALL force the following; reset mid-BONUS SHALL abort the bonus with no high-score update:
- state = IDLE
- hundreds = 0, ten_out = 0
- hi_hundreds = 0, hi_tens = 0
- bonus counter = 0, bonus_busy = 0

Configuration
REQ-031 Macro SCORE_ACCURACY_BONUS_EN:
- Defined: BONUS behaviour as in REQ-024/025.
- Undefined: the bonus counter loads 0, so BONUS lasts exactly one cycle and fire_count is unused.

Structure
REQ-032 Package score_pkg SHALL hold:
- hit type enum
- game-state constants TITLE = 0, PLAY = 1, WIN = 4, RESTART = 6
- sk_state_t FSM enum
REQ-033 Sub-module bcd2_add SHALL implement the saturating two-digit BCD add of a 0..3 increment; it SHALL be instantiated once and shared by the hit path and the bonus path (paths are mutually exclusive by state).

Verification
REQ-034 Score start: PLAY, one pulse each of types 1, 2, 3 -> 06 tens; hundreds = 0, ten_out = 6.
REQ-035 Carry: score 08, hit type 3 -> 11 tens next cycle.
REQ-036 Saturation: score 98, hit type 3 -> 99; a further hit type 1 -> remains 99.
REQ-037 Bonus: score 42, fire_count = 24, curr_state -> 4 -> bonus_busy high 7 cycles, final score 49, high score 49.
REQ-038 Clear priority: hit_valid = 1 in the same cycle as curr_state = 6 -> score 00 next cycle; high score unchanged.
REQ-039 Reset mid-BONUS with score 30 -> all outputs 0 next cycle, high score 00.
